// File: rtl/snn_lif_layer_seq_if.sv
// Handshake and configuration bundle for the time-multiplexed LIF layer.
// The controller drives the master side and the layer sits on the slave side.
interface snn_lif_layer_seq_if #(
  parameter int N_IN     = 8,
  parameter int N_OUT    = 8,
  parameter int W_BITS   = 2,
  parameter int V_BITS   = 6,
  parameter int REF_BITS = 6
);
  logic                           enable;
  logic [N_IN-1:0]                input_spikes;
  logic [N_IN*N_OUT*W_BITS-1:0]   weights;
  logic [V_BITS-1:0]              threshold;
  logic [V_BITS-1:0]              decay;
  logic [REF_BITS-1:0]            refractory_period;
  logic                           reset_mode;
  logic                           busy;
  logic                           done;
  logic [N_OUT-1:0]               output_spikes;
  logic [N_OUT*V_BITS-1:0]        membrane_potential_out;

  modport master (
    output enable, input_spikes, weights, threshold, decay, refractory_period, reset_mode,
    input  busy, done, output_spikes, membrane_potential_out
  );

  modport slave (
    input  enable, input_spikes, weights, threshold, decay, refractory_period, reset_mode,
    output busy, done, output_spikes, membrane_potential_out
  );
endinterface

// File: rtl/snn_lif_layer_seq.sv
// Leaky integrate-and-fire layer that walks one synapse per cycle through a
// single accumulator; per-neuron potential/refractory state lives in cells.
module snn_lif_cell #(
  parameter int V_BITS   = 6,
  parameter int REF_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [V_BITS-1:0]   v_d,
  input  logic [REF_BITS-1:0] ref_d,
  output logic [V_BITS-1:0]   v_q,
  output logic [REF_BITS-1:0] ref_q
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      ref_q <= '0;
    end else if (we) begin
      v_q   <= v_d;
      ref_q <= ref_d;
    end
  end
endmodule

module snn_lif_layer_seq #(
  parameter int N_IN     = 8,
  parameter int N_OUT    = 8,
  parameter int W_BITS   = 2,
  parameter int V_BITS   = 6,
  parameter int REF_BITS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  snn_lif_layer_seq_if.slave bus
);
  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int WW    = $clog2(N_IN*N_OUT*W_BITS);
  localparam int ACC_W = V_BITS + W_BITS + $clog2(N_IN) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, FINISH} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  i_q, i_d;
  logic [JW-1:0]                  j_q, j_d, j_nx;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic [N_IN-1:0]                spk_in_q, spk_in_d;
  logic [N_OUT-1:0]               stage_q, stage_d;
  logic [N_OUT-1:0]               out_spk_q, out_spk_d;

  logic [N_OUT-1:0][V_BITS-1:0]   v_all;
  logic [N_OUT-1:0][REF_BITS-1:0] ref_all;
  logic [N_OUT-1:0]               cell_we;
  logic [V_BITS-1:0]              v_new;
  logic [REF_BITS-1:0]            ref_new;

  logic [WW-1:0]                  w_idx;
  logic [W_BITS-1:0]              w_sel;
  logic signed [ACC_W-1:0]        w_ext, dec_ext, diff;
  logic [V_BITS-1:0]              s_sat;
  logic                           fire;

  assign w_idx   = WW'((int'(j_q) * N_IN + int'(i_q)) * W_BITS);
  assign w_sel   = bus.weights[w_idx +: W_BITS];
  assign w_ext   = {{(ACC_W-W_BITS){w_sel[W_BITS-1]}}, w_sel};
  assign dec_ext = {{(ACC_W-V_BITS){1'b0}}, bus.decay};
  assign diff    = acc_q - dec_ext;

  // Sign bit set means the leak drove the sum negative; any bit above V_BITS means overflow.
  always_comb begin
    s_sat = diff[V_BITS-1:0];
    if (diff[ACC_W-1])                s_sat = '0;
    else if (|diff[ACC_W-2:V_BITS])   s_sat = '1;
  end

  assign fire = (bus.threshold != '0) && (s_sat >= bus.threshold);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    spk_in_d  = spk_in_q;
    stage_d   = stage_q;
    out_spk_d = out_spk_q;
    cell_we   = '0;
    v_new     = '0;
    ref_new   = '0;
    j_nx      = j_q + JW'(1);
    case (state_q)
      // FINISH is already idle from the controller's view, so a request there starts at once.
      IDLE, FINISH: begin
        if (bus.enable) begin
          spk_in_d = bus.input_spikes;
          i_d      = '0;
          j_d      = '0;
          acc_d    = {{(ACC_W-V_BITS){1'b0}}, v_all[0]};
          state_d  = ACCUM;
        end else begin
          state_d  = IDLE;
        end
      end
      ACCUM: begin
        if (spk_in_q[i_q]) acc_d = acc_q + w_ext;
        if (i_q == IW'(N_IN-1)) state_d = UPDATE;
        else                    i_d     = i_q + IW'(1);
      end
      UPDATE: begin
        cell_we[j_q] = 1'b1;
        if (ref_all[j_q] != '0) begin
          ref_new      = ref_all[j_q] - REF_BITS'(1);
          stage_d[j_q] = 1'b0;
        end else if (fire) begin
          stage_d[j_q] = 1'b1;
          ref_new      = bus.refractory_period;
          v_new        = bus.reset_mode ? (s_sat - bus.threshold) : '0;
        end else begin
          stage_d[j_q] = 1'b0;
          v_new        = s_sat;
        end
        if (j_q == JW'(N_OUT-1)) begin
          out_spk_d = stage_d;
          state_d   = FINISH;
        end else begin
          j_d     = j_nx;
          i_d     = '0;
          acc_d   = {{(ACC_W-V_BITS){1'b0}}, v_all[j_nx]};
          state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      spk_in_q  <= '0;
      stage_q   <= '0;
      out_spk_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      spk_in_q  <= spk_in_d;
      stage_q   <= stage_d;
      out_spk_q <= out_spk_d;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_cell
    snn_lif_cell #(.V_BITS(V_BITS), .REF_BITS(REF_BITS)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (cell_we[g]),
      .v_d   (v_new),
      .ref_d (ref_new),
      .v_q   (v_all[g]),
      .ref_q (ref_all[g])
    );
  end

  assign bus.busy                   = (state_q == ACCUM) || (state_q == UPDATE);
  assign bus.done                   = (state_q == FINISH);
  assign bus.output_spikes          = out_spk_q;
  assign bus.membrane_potential_out = v_all;
endmodule

// File: tb/tb_snn_lif_layer_seq.sv
// Two layer configurations (8x8/W2 and 16x2/W3) driven with directed and random
// steps; expected results come from an array model and are checked on done.
module tb_snn_lif_layer_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_lif_layer_seq_if #(.N_IN(8),  .N_OUT(8), .W_BITS(2), .V_BITS(6), .REF_BITS(6)) bus_a();
  snn_lif_layer_seq_if #(.N_IN(16), .N_OUT(2), .W_BITS(3), .V_BITS(6), .REF_BITS(6)) bus_b();

  snn_lif_layer_seq #(.N_IN(8),  .N_OUT(8), .W_BITS(2), .V_BITS(6), .REF_BITS(6))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  snn_lif_layer_seq #(.N_IN(16), .N_OUT(2), .W_BITS(3), .V_BITS(6), .REF_BITS(6))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct packed {
    logic [7:0]      spk;
    logic [7:0][5:0] v;
    int              acc_edge;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   thr[2], dec[2], rp[2], mode[2];
  int   w[2][8][16];
  int   V[2][8], R[2][8];
  int   n_cmp = 0, n_bad = 0;
  int   edge_cnt = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int n_in(input int d);  return d ? 16 : 8; endfunction
  function automatic int n_out(input int d); return d ? 2 : 8;  endfunction

  task automatic cmp(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, required %0d", nm, edge_cnt, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at edge %0d: bound expired", nm, edge_cnt);
  endtask

  task automatic apply_cfg(input int d);
    logic [127:0] wa;
    logic [95:0]  wb;
    logic [1:0]   w2;
    logic [2:0]   w3;
    wa = '0;
    wb = '0;
    for (int j = 0; j < n_out(d); j++)
      for (int i = 0; i < n_in(d); i++) begin
        if (d == 0) begin w2 = 2'(w[0][j][i]); wa = wa | (128'(w2) << ((j*8 + i)*2));  end
        else        begin w3 = 3'(w[1][j][i]); wb = wb | (96'(w3)  << ((j*16 + i)*3)); end
      end
    if (d == 0) begin
      bus_a.weights = wa; bus_a.threshold = 6'(thr[0]); bus_a.decay = 6'(dec[0]);
      bus_a.refractory_period = 6'(rp[0]); bus_a.reset_mode = mode[0][0];
    end else begin
      bus_b.weights = wb; bus_b.threshold = 6'(thr[1]); bus_b.decay = 6'(dec[1]);
      bus_b.refractory_period = 6'(rp[1]); bus_b.reset_mode = mode[1][0];
    end
  endtask

  task automatic set_cfg(input int d, input int wv, input int t, input int dc, input int r, input int m);
    thr[d] = t; dec[d] = dc; rp[d] = r; mode[d] = m;
    for (int j = 0; j < 8; j++) for (int i = 0; i < 16; i++) w[d][j][i] = wv;
    apply_cfg(d);
  endtask

  task automatic rand_cfg(input int d);
    thr[d]  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
    dec[d]  = $urandom_range(0, 3);
    rp[d]   = $urandom_range(0, 3);
    mode[d] = $urandom_range(0, 1);
    for (int j = 0; j < 8; j++) for (int i = 0; i < 16; i++)
      w[d][j][i] = d ? (int'($urandom_range(0, 7)) - 4) : (int'($urandom_range(0, 3)) - 2);
    apply_cfg(d);
  endtask

  // Reference: one full layer step from the neuron rules, in plain integer arithmetic.
  task automatic model_step(input int d, input logic [15:0] spk, output exp_t e);
    int acc, s;
    e = '0;
    for (int j = 0; j < n_out(d); j++) begin
      if (R[d][j] != 0) begin
        R[d][j] = R[d][j] - 1;
        V[d][j] = 0;
      end else begin
        acc = V[d][j];
        for (int i = 0; i < n_in(d); i++) if (spk[i]) acc += w[d][j][i];
        s = acc - dec[d];
        if (s < 0)  s = 0;
        if (s > 63) s = 63;
        if (thr[d] != 0 && s >= thr[d]) begin
          e.spk[j] = 1'b1;
          R[d][j]  = rp[d];
          V[d][j]  = mode[d] ? s - thr[d] : 0;
        end else begin
          V[d][j]  = s;
        end
      end
      e.v[j] = 6'(V[d][j]);
    end
  endtask

  function automatic logic busy_of(input int d);
    return d ? bus_b.busy : bus_a.busy;
  endfunction

  task automatic issue(input int d, input logic [15:0] spk, input bit hold, output int ae);
    int   n;
    exp_t e;
    n  = 0;
    ae = -1;
    @(negedge clk);
    while (busy_of(d)) begin
      @(negedge clk);
      n++;
      if (n > 300) begin fail_now("idle_wait"); return; end
    end
    model_step(d, spk, e);
    e.acc_edge = edge_cnt + 1;
    ae = e.acc_edge;
    if (d == 0) begin bus_a.input_spikes = spk[7:0]; bus_a.enable = 1'b1; q0.push_back(e); end
    else        begin bus_b.input_spikes = spk;      bus_b.enable = 1'b1; q1.push_back(e); end
    if (!hold) begin
      @(posedge clk); #1;
      if (d == 0) bus_a.enable = 1'b0; else bus_b.enable = 1'b0;
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((d ? q1.size() : q0.size()) != 0) begin
      @(negedge clk);
      n++;
      if (n > 400) begin fail_now("drain"); return; end
    end
  endtask

  task automatic mon(input int d);
    logic        b, dn;
    logic [7:0]  os;
    logic [47:0] mp;
    bit          have;
    exp_t        f;
    int          lat, r;
    have = 1'b0;
    f    = '0;
    if (d == 0) begin
      b = bus_a.busy; dn = bus_a.done; os = bus_a.output_spikes; mp = bus_a.membrane_potential_out;
      if (q0.size() > 0) begin have = 1'b1; f = q0[0]; end
    end else begin
      b = bus_b.busy; dn = bus_b.done; os = {6'b0, bus_b.output_spikes};
      mp = {36'b0, bus_b.membrane_potential_out};
      if (q1.size() > 0) begin have = 1'b1; f = q1[0]; end
    end
    lat = n_out(d) * (n_in(d) + 1) + 1;
    r   = have ? edge_cnt - f.acc_edge + 1 : 0;
    cmp($sformatf("busy_dut%0d", d), int'(b),  int'(have && r >= 1 && r < lat));
    cmp($sformatf("done_dut%0d", d), int'(dn), int'(have && r == lat));
    if (have && r >= lat) begin
      if (r == lat) begin
        cmp($sformatf("spikes_dut%0d", d), int'(os), int'(f.spk));
        for (int j = 0; j < n_out(d); j++)
          cmp($sformatf("v%0d_dut%0d", j, d), int'(6'(mp >> (j*6))), int'(f.v[j]));
      end
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (mon_on) begin mon(0); mon(1); end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at edge %0d: simulation time limit", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3;
    bus_a.enable = 1'b0; bus_a.input_spikes = '0;
    bus_b.enable = 1'b0; bus_b.input_spikes = '0;
    for (int d = 0; d < 2; d++) begin
      set_cfg(d, 0, 0, 0, 0, 0);
      for (int j = 0; j < 8; j++) begin V[d][j] = 0; R[d][j] = 0; end
    end
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Reset during an active step discards it.
    set_cfg(0, 1, 3, 0, 0, 0);
    issue(0, 16'h000F, 1'b0, a1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    for (int d = 0; d < 2; d++) for (int j = 0; j < 8; j++) begin V[d][j] = 0; R[d][j] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp("rst_spikes", int'(bus_a.output_spikes), 0);
    for (int j = 0; j < 8; j++) cmp("rst_v", int'(6'(bus_a.membrane_potential_out >> (j*6))), 0);
    repeat (90) @(negedge clk);

    // Single fire at defaults.
    issue(0, 16'h000F, 1'b0, a1);
    wait_idle(0);

    // Leak with negative weights floors at zero, then gain equals leak.
    set_cfg(0, -1, 3, 1, 0, 0);
    issue(0, 16'h00FF, 1'b0, a1);
    wait_idle(0);
    set_cfg(0, 1, 63, 1, 0, 0);
    repeat (5) issue(0, 16'h0001, 1'b0, a1);
    wait_idle(0);

    // Refractory period, then subtractive reset.
    set_cfg(0, 1, 2, 0, 2, 0);
    repeat (6) issue(0, 16'h0007, 1'b0, a1);
    wait_idle(0);
    set_cfg(0, 1, 2, 0, 2, 1);
    issue(0, 16'h0007, 1'b0, a1);
    wait_idle(0);

    // Saturation with firing disabled.
    set_cfg(0, 1, 0, 0, 0, 0);
    repeat (9) issue(0, 16'h00FF, 1'b0, a1);
    wait_idle(0);

    // Enable held high: back-to-back accepts every step length.
    set_cfg(0, 1, 5, 1, 1, 0);
    issue(0, 16'h00F3, 1'b1, a1);
    issue(0, 16'h003C, 1'b1, a2);
    cmp("accept_gap1", a2 - a1, 73);
    issue(0, 16'h00FF, 1'b1, a3);
    cmp("accept_gap2", a3 - a2, 73);
    @(posedge clk); #1 bus_a.enable = 1'b0;
    wait_idle(0);

    // A pulse while busy must be ignored.
    issue(0, 16'h0055, 1'b0, a1);
    repeat (10) @(negedge clk);
    bus_a.enable = 1'b1;
    @(negedge clk);
    bus_a.enable = 1'b0;
    wait_idle(0);
    repeat (10) @(negedge clk);

    // Random steps on the default layer.
    for (int k = 0; k < 15; k++) begin
      if (k % 3 == 0) begin wait_idle(0); rand_cfg(0); end
      issue(0, 16'($urandom_range(0, 255)), 1'b0, a1);
    end
    wait_idle(0);

    // Wide layer: weight index mapping per neuron, then random.
    for (int j = 0; j < 8; j++) for (int i = 0; i < 16; i++) w[1][j][i] = 0;
    w[1][1][15] = 3; w[1][0][15] = -1; w[1][0][0] = 2; w[1][1][1] = -4;
    thr[1] = 0; dec[1] = 0; rp[1] = 0; mode[1] = 0;
    apply_cfg(1);
    issue(1, 16'h8000, 1'b0, a1);
    issue(1, 16'h8001, 1'b0, a1);
    issue(1, 16'h0002, 1'b0, a1);
    wait_idle(1);
    for (int k = 0; k < 12; k++) begin
      if (k % 3 == 0) begin wait_idle(1); rand_cfg(1); end
      issue(1, 16'($urandom_range(0, 65535)), 1'b0, a1);
    end
    wait_idle(1);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snn_lif_layer_seq.md
Name: snn_lif_layer_seq

Overview:
- Parametrised, time-multiplexed leaky integrate-and-fire layer. It is the next-generation replacement for the fixed 8-input, 2-output combinational-parallel layer in the SNN core.
- It processes one synapse per cycle, so any N_IN x N_OUT layer reuses a single adder.
- It adds a selectable post-spike reset mode and a start/done handshake for the system_clock domain controller.
- It sits between the synchronised SPI configuration fields and the debug/output muxes.

Parameters:
N_IN, 8, number of input spike lines
N_OUT, 8, number of neurons in the layer
W_BITS, 2, signed two's-complement weight width
V_BITS, 6, unsigned membrane potential / threshold / decay width
REF_BITS, 6, refractory counter width

Ports:
clk  in  1  system clock; the block's only clock
rst_n  in  1  synchronous, active-low reset
enable  in  1  start request; sampled only in IDLE
input_spikes  in  N_IN  spike vector, latched when enable is accepted
weights  in  N_IN*N_OUT*W_BITS  weight of input i to neuron j is at [(j*N_IN+i)*W_BITS +: W_BITS]
threshold  in  V_BITS  firing threshold; 0 disables firing for all neurons
decay  in  V_BITS  leak subtracted once per step
refractory_period  in  REF_BITS  number of steps a neuron is silent after a spike
reset_mode  in  1  0: potential goes to 0 after a spike; 1: threshold is subtracted after a spike
busy  out  1  high from the accept edge until done
done  out  1  one-cycle pulse at the end of a step
output_spikes  out  N_OUT  spikes from the last completed step
membrane_potential_out  out  N_OUT*V_BITS  potential of neuron j at [j*V_BITS +: V_BITS]

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- When rst_n=0 at an edge:
  - FSM goes to IDLE.
  - busy=0, done=0, output_spikes=0.
  - All potentials and refractory counters are 0.
  - An in-flight step is discarded; no partial spikes are published.
- FSM states: IDLE, ACCUM, UPDATE, FINISH.
- IDLE:
  - enable=1 → latch input_spikes; set j=0, i=0; acc=V[0] (zero-extended); busy=1; go to ACCUM.
  - While busy=1, enable is ignored. Requests are not queued.
- ACCUM:
  - Each cycle, if spike[i] then acc += sign_extend(w[j][i]).
  - i increments. After i=N_IN-1, go to UPDATE.
  - acc is signed, width V_BITS+W_BITS+clog2(N_IN)+1, so it cannot overflow.
- UPDATE (1 cycle, neuron j):
  - If ref[j]≠0: ref[j]--, V[j]=0, spike[j]=0. The accumulated input is discarded.
  - Otherwise:
    - s = clamp(acc − decay) to [0, 2^V_BITS−1].
    - If threshold≠0 and s≥threshold: spike[j]=1, ref[j]=refractory_period, and V[j]=0 (mode 0) or s−threshold (mode 1).
    - Else: spike[j]=0, V[j]=s.
  - If j=N_OUT−1, go to FINISH. Otherwise j++, i=0, acc=V[j+1], go to ACCUM.
- FINISH (1 cycle):
  - output_spikes ← staged spike vector, updated atomically.
  - done=1, busy=0. Next state is IDLE.
- membrane_potential_out reflects V[] registers live, including mid-step updates.
- Latency: counting the enable-accept edge as edge 1, done is high in the cycle after edge 1+N_OUT*(N_IN+1). At defaults that is edge 73.
- The earliest next accept is the edge where done=1, because the state is already IDLE.
- Config inputs (weights, threshold, decay, refractory_period, reset_mode) are read live and must be stable while busy. Only input_spikes is latched.
- Saturation boundaries:
  - Negative sums floor at 0.
  - Sums above 2^V_BITS−1 cap at 2^V_BITS−1.
  - refractory_period=0 means no refractory silence.

Test Plan:
1. Reset and idle: hold rst_n=0 for 3 edges during an active step, then release → busy=0, done=0, output_spikes=0, all potentials 0. No done pulse follows.
2. Single fire, defaults:
   - Setup: threshold=3, decay=0, mode 0, all weights +1, input_spikes=0x0F.
   - Expect: every neuron sum=4 → output_spikes=0xFF, all V=0.
   - Expect done exactly at edge 73; busy high on edges 1–72.
3. Leak and negative weights:
   - Setup: weights −1, decay=1, input_spikes=0xFF, starting V=0.
   - Expect: V stays 0 (floor), no spikes.
   - Then set weights +1, threshold=63, input_spikes=0x01 for 5 steps → V=0 after every step (gain 1 − leak 1 = 0).
4. Refractory and reset_mode:
   - Setup: refractory_period=2, threshold=2, weights +1, input_spikes=0x07, decay=0.
   - Mode 0: step 1 spikes (V=0), steps 2–3 silent with V=0, step 4 spikes again.
   - Mode 1: step 1 gives s=3 → V=1 after spike.
5. Saturation and threshold=0:
   - Setup: V_BITS=6, weights +1, input_spikes=0xFF, threshold=0, decay=0.
   - Expect: V caps at 63 after 8 steps and never spikes.
6. Handshake and parameters:
   - Assert enable continuously → accepts exactly every 73 edges; pulses while busy are ignored.
   - Repeat with N_IN=16, N_OUT=2, W_BITS=3 → done at edge 35; weight index mapping verified per neuron.
